// File: rtl/hog_pkg.sv
// hog_pkg: constants, state encoding and arithmetic helpers shared by the
// HOG cell-histogram accumulator and its position counter.
package hog_pkg;

    localparam int NBINS = 18;  // orientation bins per cell
    localparam int BIN_W = 5;   // width of a bin number

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_DRAIN = 1'b1
    } state_e;

    // Unsigned add clamped to 2^w-1. Operands are passed widened to 64 bits,
    // so the carry out of a w-bit add is never lost (w < 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int          w);
        logic [63:0] sum;
        logic [63:0] max_v;
        sum   = a + b;
        max_v = (64'd1 << w) - 64'd1;
        return (sum > max_v) ? max_v : sum;
    endfunction

endpackage

// File: rtl/hog_pos_counter.sv
// hog_pos_counter: raster position tracker for the histogram accumulator.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   adv_i          : a pixel was accepted this cycle
//   band_done_i    : the drain of the current band completed this cycle
//   px_x_o, px_y_o : position of the next pixel to be accepted
//   band_o         : index of the band being accumulated / drained
//   band_end_o     : next pixel is the last pixel of its band
//   frame_end_o    : current band is the last band of the frame
module hog_pos_counter
    import hog_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int CELL  = 8,
    parameter int XW    = 6,
    parameter int YW    = 6,
    parameter int BW    = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          adv_i,
    input  logic          band_done_i,
    output logic [XW-1:0] px_x_o,
    output logic [YW-1:0] px_y_o,
    output logic [BW-1:0] band_o,
    output logic          band_end_o,
    output logic          frame_end_o
);

    localparam int NCY = IMG_H / CELL;

    logic [XW-1:0] px_x_q, px_x_d;
    logic [YW-1:0] px_y_q, px_y_d;
    logic [BW-1:0] band_q, band_d;

    assign px_x_o = px_x_q;
    assign px_y_o = px_y_q;
    assign band_o = band_q;

    // CELL is a power of two, so the row-within-cell is a simple mask.
    assign band_end_o  = (px_x_q == XW'(IMG_W - 1)) &&
                         ((px_y_q & YW'(CELL - 1)) == YW'(CELL - 1));
    assign frame_end_o = (band_q == BW'(NCY - 1));

    always_comb begin
        px_x_d = px_x_q;
        px_y_d = px_y_q;
        band_d = band_q;
        if (adv_i) begin
            if (px_x_q == XW'(IMG_W - 1)) begin
                px_x_d = '0;
                px_y_d = (px_y_q == YW'(IMG_H - 1)) ? '0 : px_y_q + 1'b1;
            end else begin
                px_x_d = px_x_q + 1'b1;
            end
        end
        // The band index must stay on the drained band until its last beat,
        // so it steps on drain completion rather than on the final pixel.
        if (band_done_i) begin
            band_d = frame_end_o ? '0 : band_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            px_x_q <= '0;
            px_y_q <= '0;
            band_q <= '0;
        end else begin
            px_x_q <= px_x_d;
            px_y_q <= px_y_d;
            band_q <= band_d;
        end
    end

endmodule

// File: rtl/hog_cell_hist_accum.sv
// hog_cell_hist_accum: accumulates per-pixel orientation votes into 18-bin
// histograms for one band of cells, then drains the band one bin per beat.
//   aclk, arest            : clock, synchronous active-high reset
//   bin_num, mag, in_valid : pixel vote input; in_ready accepts it
//   hist_data/valid/ready  : drained bin value stream
//   hist_last              : beat carries bin 17 of a cell
//   hist_cell_x/y          : cell coordinates of the current beat
//   frame_done             : pulse after the final beat of the frame
//   bin_err                : sticky, a bin number >= 18 was received
module hog_cell_hist_accum
    import hog_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int CELL  = 8,
    parameter int MAG_W = 16,
    parameter int ACC_W = 24,
    localparam int NCX  = IMG_W / CELL,
    localparam int NCY  = IMG_H / CELL,
    localparam int CXW  = (NCX > 1) ? $clog2(NCX) : 1,
    localparam int CYW  = (NCY > 1) ? $clog2(NCY) : 1
) (
    input  logic             aclk,
    input  logic             arest,
    input  logic [BIN_W-1:0] bin_num,
    input  logic [MAG_W-1:0] mag,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] hist_data,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic             hist_last,
    output logic [CXW-1:0]   hist_cell_x,
    output logic [CYW-1:0]   hist_cell_y,
    output logic             frame_done,
    output logic             bin_err
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CL = $clog2(CELL);

    state_e           state_q, state_d;
    logic             rdy_q;
    logic             fdone_q;
    logic             bin_err_q;
    logic [CXW-1:0]   rd_cx_q;
    logic [BIN_W-1:0] rd_bin_q;
    logic [ACC_W-1:0] acc_q [NCX][NBINS];

    logic [XW-1:0]    px_x;
    logic [YW-1:0]    px_y;
    logic [CYW-1:0]   band;
    logic             band_end;
    logic             frame_end;
    logic [CXW-1:0]   px_cx;
    logic             accept;
    logic             bin_ok;
    logic             drain;
    logic             hs;
    logic             rd_last;
    logic             band_done;

    hog_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CELL  (CELL),
        .XW    (XW),
        .YW    (YW),
        .BW    (CYW)
    ) u_pos (
        .clk_i       (aclk),
        .rst_i       (arest),
        .adv_i       (accept),
        .band_done_i (band_done),
        .px_x_o      (px_x),
        .px_y_o      (px_y),
        .band_o      (band),
        .band_end_o  (band_end),
        .frame_end_o (frame_end)
    );

    assign px_cx     = CXW'(px_x >> CL);
    assign accept    = in_valid & rdy_q;
    assign bin_ok    = (bin_num < BIN_W'(NBINS));
    assign drain     = (state_q == S_DRAIN);
    assign hs        = drain & hist_ready;
    assign rd_last   = (rd_cx_q == CXW'(NCX - 1)) && (rd_bin_q == BIN_W'(NBINS - 1));
    assign band_done = hs & rd_last;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACCUM: if (accept && band_end) state_d = S_DRAIN;
            S_DRAIN: if (band_done)          state_d = S_ACCUM;
            default: state_d = S_ACCUM;
        endcase
    end

    // Control registers. in_ready is registered from the next state so it is
    // low through reset and independent of in_valid / hist_ready.
    always_ff @(posedge aclk) begin
        if (arest) begin
            state_q   <= S_ACCUM;
            rdy_q     <= 1'b0;
            fdone_q   <= 1'b0;
            bin_err_q <= 1'b0;
            rd_cx_q   <= '0;
            rd_bin_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == S_ACCUM);
            fdone_q <= band_done & frame_end;
            if (accept && !bin_ok) bin_err_q <= 1'b1;
            if (hs) begin
                if (rd_bin_q == BIN_W'(NBINS - 1)) begin
                    rd_bin_q <= '0;
                    rd_cx_q  <= rd_last ? '0 : rd_cx_q + 1'b1;
                end else begin
                    rd_bin_q <= rd_bin_q + 1'b1;
                end
            end
        end
    end

    // Accumulator bank. Accumulate and drain happen in different states, so a
    // single entry is never both added to and cleared in the same cycle.
    always_ff @(posedge aclk) begin
        if (arest) begin
            for (int c = 0; c < NCX; c++) begin
                for (int b = 0; b < NBINS; b++) begin
                    acc_q[c][b] <= '0;
                end
            end
        end else begin
            if (accept && bin_ok) begin
                acc_q[px_cx][bin_num] <= ACC_W'(sat_add(64'(acc_q[px_cx][bin_num]),
                                                        64'(mag), ACC_W));
            end
            if (hs) begin
                acc_q[rd_cx_q][rd_bin_q] <= '0;
            end
        end
    end

    assign in_ready    = rdy_q;
    assign hist_valid  = drain;
    assign hist_data   = drain ? acc_q[rd_cx_q][rd_bin_q] : '0;
    assign hist_last   = drain && (rd_bin_q == BIN_W'(NBINS - 1));
    assign hist_cell_x = drain ? rd_cx_q : '0;
    assign hist_cell_y = drain ? band : '0;
    assign frame_done  = fdone_q;
    assign bin_err     = bin_err_q;

endmodule

// File: tb/tb_hog_cell_hist_accum.sv
module tb_hog_cell_hist_accum;

    localparam int IMG_W = 16;
    localparam int IMG_H = 16;
    localparam int CELL  = 8;
    localparam int NCX   = 2;
    localparam int NCY   = 2;
    localparam int NB    = 18;
    localparam int BEATS = NCX * NB;
    localparam int BAND_PIX = IMG_W * CELL;

    logic        aclk = 1'b0;
    logic        arest;
    logic [4:0]  bin_num;
    logic [15:0] mag;
    logic        in_valid;
    logic        hist_ready;

    logic        in_ready,  in_ready16;
    logic [23:0] hist_data;
    logic [15:0] hist_data16;
    logic        hist_valid, hist_valid16;
    logic        hist_last,  hist_last16;
    logic [0:0]  hist_cell_x, hist_cell_x16;
    logic [0:0]  hist_cell_y, hist_cell_y16;
    logic        frame_done, frame_done16;
    logic        bin_err,    bin_err16;

    always #5 aclk = ~aclk;

    hog_cell_hist_accum #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CELL(CELL),
                          .MAG_W(16), .ACC_W(24)) dut (
        .aclk(aclk), .arest(arest), .bin_num(bin_num), .mag(mag),
        .in_valid(in_valid), .in_ready(in_ready), .hist_data(hist_data),
        .hist_valid(hist_valid), .hist_ready(hist_ready), .hist_last(hist_last),
        .hist_cell_x(hist_cell_x), .hist_cell_y(hist_cell_y),
        .frame_done(frame_done), .bin_err(bin_err));

    // Narrow-accumulator instance sharing the same stimulus, for saturation.
    hog_cell_hist_accum #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CELL(CELL),
                          .MAG_W(16), .ACC_W(16)) dut16 (
        .aclk(aclk), .arest(arest), .bin_num(bin_num), .mag(mag),
        .in_valid(in_valid), .in_ready(in_ready16), .hist_data(hist_data16),
        .hist_valid(hist_valid16), .hist_ready(hist_ready), .hist_last(hist_last16),
        .hist_cell_x(hist_cell_x16), .hist_cell_y(hist_cell_y16),
        .frame_done(frame_done16), .bin_err(bin_err16));

    int total = 0;
    int bad   = 0;

    // Reference model: per-cell bin sums for each accumulator width.
    longint m24 [NCX][NB];
    longint m16 [NCX][NB];
    bit     exp_err;
    int     tb_band;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCX; c++)
            for (int b = 0; b < NB; b++) begin
                m24[c][b] = 0;
                m16[c][b] = 0;
            end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_hvalid"}, hist_valid, 0);
        chk({tag, "_hdata"},  hist_data, 0);
        chk({tag, "_hlast"},  hist_last, 0);
        chk({tag, "_cx"},     hist_cell_x, 0);
        chk({tag, "_cy"},     hist_cell_y, 0);
        chk({tag, "_fdone"},  frame_done, 0);
        chk({tag, "_binerr"}, bin_err, 0);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        arest = 1'b1; in_valid = 1'b0; hist_ready = 1'b0;
        bin_num = '0; mag = '0;
        @(negedge aclk);
        chk("rst_in_ready", in_ready, 0);
        chk_idle_outs("rst");
        @(negedge aclk);
        arest = 1'b0;
        @(negedge aclk);
        chk("rel_in_ready", in_ready, 1);
        chk_idle_outs("rel");
        model_clear();
        exp_err = 1'b0;
        tb_band = 0;
    endtask

    // mode 0: all bin 3 / mag 10; 1: random with one bad bin; 2: cell 0 bin 0 at full mag.
    task automatic drive_band(input int mode);
        int p, b, m, px, cx, errpos;
        errpos = $urandom_range(0, BAND_PIX - 1);
        p = 0;
        while (p < BAND_PIX) begin
            @(negedge aclk);
            if (!in_ready) begin
                chk("accum_in_ready", in_ready, 1);
                $fatal(1, "input stalled during accumulation");
            end
            if (mode != 0 && ($urandom % 4) == 0) begin
                in_valid = 1'b0;
                continue;
            end
            px = p % IMG_W;
            cx = px / CELL;
            b  = $urandom_range(0, NB - 1);
            m  = $urandom_range(0, 65535);
            if (mode == 0) begin b = 3; m = 10; end
            if (mode == 1 && p == errpos) b = 18;
            if (mode == 2 && cx == 0) begin b = 0; m = 65535; end
            in_valid = 1'b1; bin_num = 5'(b); mag = 16'(m);
            @(posedge aclk);
            if (b < NB) begin
                m24[cx][b] = sat(m24[cx][b] + m, 24);
                m16[cx][b] = sat(m16[cx][b] + m, 16);
            end else begin
                exp_err = 1'b1;
            end
            p++;
        end
    endtask

    // Drains one band, checking each beat; stop_at >= 0 abandons at that beat.
    task automatic drain_band(input bit rnd_ready, input int stop_at);
        longint e24 [BEATS];
        longint e16 [BEATS];
        int beat, low;
        bit prev_stall;
        logic [23:0] prev_data;
        for (int i = 0; i < BEATS; i++) begin
            e24[i] = m24[i / NB][i % NB];
            e16[i] = m16[i / NB][i % NB];
        end
        model_clear();
        beat = 0; low = 0; prev_stall = 1'b0; prev_data = '0;
        for (int cyc = 0; cyc < 400 && beat < BEATS; cyc++) begin
            @(negedge aclk);
            in_valid = 1'b0;
            if (!in_ready) low++;
            chk("drain_valid",   hist_valid, 1);
            chk("drain_valid16", hist_valid16, 1);
            chk("drain_data",    hist_data, e24[beat]);
            chk("drain_data16",  hist_data16, e16[beat]);
            chk("drain_last",    hist_last, (beat % NB) == NB - 1);
            chk("drain_cx",      hist_cell_x, beat / NB);
            chk("drain_cy",      hist_cell_y, tb_band);
            chk("drain_fdone",   frame_done, 0);
            if (prev_stall) chk("stall_hold", hist_data, prev_data);
            if (beat == stop_at) return;
            hist_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
            prev_stall = !hist_ready;
            prev_data  = hist_data;
            if (hist_ready) beat++;
        end
        if (beat < BEATS) chk("drain_timeout", beat, BEATS);
        @(negedge aclk);
        hist_ready = 1'b0;
        chk("end_fdone",    frame_done, tb_band == NCY - 1);
        chk("end_in_ready", in_ready, 1);
        chk("end_hvalid",   hist_valid, 0);
        if (!rnd_ready) chk("ready_low_cycles", low, BEATS);
        @(negedge aclk);
        chk("fdone_pulse", frame_done, 0);
        tb_band = (tb_band + 1) % NCY;
    endtask

    initial begin
        arest = 1'b1; in_valid = 1'b0; hist_ready = 1'b0;
        bin_num = '0; mag = '0;
        exp_err = 1'b0; tb_band = 0;
        model_clear();
        do_reset();

        drive_band(0); drain_band(1'b0, -1);   // band 0, steady ready
        drive_band(0); drain_band(1'b1, -1);   // band 1, random stalls
        drive_band(1); drain_band(1'b1, -1);   // random votes, one bad bin
        chk("bin_err_set", bin_err, exp_err);
        drive_band(2); drain_band(1'b0, -1);   // saturation of the narrow bank
        chk("bin_err_sticky", bin_err, 1);

        drive_band(1); drain_band(1'b1, 10);   // abandon mid-drain
        do_reset();
        chk("bin_err_cleared", bin_err, 0);

        drive_band(1); drain_band(1'b1, -1);
        drive_band(1); drain_band(1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hog_cell_hist_accum.md
# hog_cell_hist_accum

Accumulates per-pixel HOG orientation votes into 18-bin cell histograms. It sits directly downstream of the bin-classification stage and consumes that stage's bin number, together with the pixel's gradient magnitude. Pixels arrive in raster order. Histograms for a complete horizontal band of cells are kept in a register bank. The bank is drained, one bin word per beat, to the block-normalisation stage.

## Interface
Parameters:
- IMG_W, 64: image width in pixels; multiple of CELL.
- IMG_H, 64: image height in pixels; multiple of CELL.
- CELL, 8: cell edge in pixels; power of two.
- MAG_W, 16: magnitude width, unsigned.
- ACC_W, 24: accumulator width, unsigned; must be ≥ MAG_W.

Ports (clock and reset first):
- aclk  in  1  clock. One clock; reset is synchronous and active-high.
- arest  in  1  synchronous reset, active-high.
- bin_num  in  5  orientation bin, 0..17; qualified by in_valid.
- mag  in  MAG_W  gradient magnitude, cycle-aligned with bin_num.
- in_valid  in  1  pixel valid.
- in_ready  out  1  block accepts a pixel this cycle.
- hist_data  out  ACC_W  accumulated bin value.
- hist_valid  out  1  hist_data valid.
- hist_ready  in  1  downstream accepts the beat.
- hist_last  out  1  marks bin 17 of the current cell.
- hist_cell_x  out  max(1,clog2(IMG_W/CELL))  cell column of the current beat.
- hist_cell_y  out  max(1,clog2(IMG_H/CELL))  cell row of the current beat.
- frame_done  out  1  one-cycle pulse after the final beat of the frame.
- bin_err  out  1  sticky flag: a bin_num ≥ 18 was seen.

## Operation
- Derived constants: NCX = IMG_W/CELL, NCY = IMG_H/CELL. The bank holds NCX×18 unsigned accumulators of ACC_W bits, indexed cell_x*18+bin.
- State S_ACCUM:
  - in_ready = 1.
  - On each accepted pixel (in_valid & in_ready), add mag to acc[px_x/CELL][bin_num].
  - The add saturates at 2^ACC_W−1.
  - Advance px_x. When px_x wraps at IMG_W, increment px_y.
- bin_num ≥ 18: the pixel is counted for position, no accumulator changes, and bin_err is set.
- Transition S_ACCUM → S_DRAIN occurs on acceptance of the pixel with px_x = IMG_W−1 and px_y mod CELL = CELL−1.
- State S_DRAIN:
  - in_ready = 0, hist_valid = 1.
  - Beats are emitted in order cell_x 0..NCX−1, and within each cell bin 0..17.
  - hist_data = acc[rd_idx]; hist_cell_y = band index.
  - On each handshake (hist_valid & hist_ready): clear the emitted accumulator to 0, then advance rd_idx.
  - After the beat with rd_idx = NCX*18−1 is accepted, return to S_ACCUM and reset rd_idx to 0.
  - If that band was band NCY−1: pulse frame_done, wrap px_y and the band counter to 0.
- in_valid is ignored while in_ready = 0; upstream must hold its data.
- Reset (any time, including mid-drain) does all of the following:
  - all accumulators to 0;
  - px_x, px_y, band counter and rd_idx to 0;
  - state to S_ACCUM;
  - bin_err to 0.
- Reset values of outputs: in_ready 0 while arest = 1, then 1; hist_valid 0; hist_data 0; hist_last 0; hist_cell_x 0; hist_cell_y 0; frame_done 0; bin_err 0.

## Timing
- Input path: zero-cycle acceptance. The accumulator update is visible the cycle after acceptance.
- Drain start: hist_valid rises the cycle after the band's last pixel is accepted. The first beat includes that last pixel's contribution.
- Drain length: exactly NCX*18 cycles when hist_ready is held at 1. Throughput is one beat per cycle.
- Backpressure: while hist_valid = 1 and hist_ready = 0, hist_data, hist_last, hist_cell_x and hist_cell_y hold stable.
- hist_data, hist_last, hist_cell_x and hist_cell_y are driven from registers and rd_idx only. There is no combinational path from hist_ready.
- in_ready is a function of state only; there is no combinational path from in_valid.
- frame_done is asserted in the cycle after the final frame handshake, the same cycle in_ready returns to 1.

## Structure
- Shared package hog_pkg holds:
  - NBINS = 18;
  - BIN_W = 5;
  - the state enum {S_ACCUM, S_DRAIN};
  - a saturating-add function.
- One sub-module, hog_pos_counter, owns px_x, px_y, the band counter, band_end and frame_end flags. The top level holds the bank, the FSM and the drain index.

## Test plan
Bench configuration unless noted: IMG_W=16, IMG_H=16, CELL=8 (NCX=2, NCY=2).
- Reset, then release: in_ready = 1 one cycle after release; every other output is 0.
- Band of 128 pixels, all bin 3, mag 10, hist_ready = 1 → 36 consecutive beats. cell 0 and cell 1 each show bin 3 = 640 and all other bins 0. hist_last is high on beats 18 and 36. in_ready is 0 for exactly 36 cycles.
- Same band with hist_ready toggling on a random 50% pattern → identical beat sequence, no drops, outputs stable during stalls. Accumulators read 0 on the next band.
- Override ACC_W=16: 64 pixels in cell 0, bin 0, mag 65535 → hist_data = 65535 (saturated).
- One pixel with bin_num = 18, mag 100 → bin_err stays 1. All bins are unchanged, and pixel counting is unaffected (drain still starts after pixel 128).
- Reset asserted mid-drain at beat 10 → hist_valid = 0 the next cycle. A following full 2-band frame gives correct sums, hist_cell_y = 0 then 1, and a single frame_done pulse after beat 36 of band 1.
